// File: rtl/coin_acceptor.sv
// Coin intake and credit controller. Synchronizes and edge-detects the coin sensor lines,
// accumulates credit up to MAX_CREDIT and serves vend/cancel requests. Balances are paid out as
// a one-cycle nonzero `change` value, followed by a PAYOUT_HOLD-cycle hold-off.
// Optional feature: define COIN_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples per coin.
module coin_acceptor #(
  parameter int unsigned MAX_CREDIT      = 1000,
  parameter int unsigned PAYOUT_HOLD     = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inquarter,
  input  logic       indime,
  input  logic       innickel,
  input  logic [9:0] price,
  input  logic       vend,
  input  logic       cancel,
  output logic [9:0] credit,
  output logic       vendok,
  output logic       vendfail,
  output logic       outreject,
  output logic [9:0] change,
  output logic       busy
);

  // Elaboration-time parameter range checks.
  if (MAX_CREDIT < 25 || MAX_CREDIT > 1023) begin : g_bad_max_credit
    $error("MAX_CREDIT out of range 25..1023");
  end
  if (PAYOUT_HOLD == 0 || PAYOUT_HOLD > 255) begin : g_bad_payout_hold
    $error("PAYOUT_HOLD out of range 1..255");
  end
  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..15");
  end

  localparam logic [10:0] MaxCredit = 11'(MAX_CREDIT);
  localparam logic [7:0]  HoldLoad  = 8'(PAYOUT_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StPayout, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [9:0]  credit_q, credit_d;
  logic [9:0]  change_q, change_d;
  logic        vendok_q, vendok_d;
  logic        vendfail_q, vendfail_d;
  logic        outreject_q, outreject_d;

  // Bit order for all coin vectors: [2] quarter, [1] dime, [0] nickel.
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  coin_ev;
  logic        multi_ev;
  logic [9:0]  coin_val;
  logic [10:0] coin_sum;
  logic        req_taken;

  // Two-flop synchronizer on the raw sensor lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {inquarter, indime, innickel};
      sync2_q <= sync1_q;
    end
  end

`ifdef COIN_DEBOUNCE_EN
  localparam logic [3:0] DbLast = 4'(DEBOUNCE_CYCLES - 1);

  logic [2:0][3:0] db_cnt_q;
  logic [2:0]      armed_q;

  // Armed lines count consecutive highs; disarmed lines count consecutive lows to re-arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      armed_q  <= '1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (armed_q[i] == sync2_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            db_cnt_q[i] <= '0;
            armed_q[i]  <= ~armed_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 4'd1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // An event fires on the last required high sample of an armed line.
  always_comb begin
    coin_ev = '0;
    for (int i = 0; i < 3; i++) begin
      coin_ev[i] = armed_q[i] & sync2_q[i] & (db_cnt_q[i] == DbLast);
    end
  end
`else
  logic [2:0] prev_q;

  // Previous synchronized value for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync2_q;
    end
  end

  // Every synchronized rising edge is a coin event.
  always_comb begin
    coin_ev = sync2_q & ~prev_q;
  end
`endif

  // Coin value and cap sum; multiple simultaneous events are rejected as a group.
  always_comb begin
    multi_ev = (coin_ev[0] & coin_ev[1]) | (coin_ev[0] & coin_ev[2]) | (coin_ev[1] & coin_ev[2]);
    if (coin_ev[2]) begin
      coin_val = 10'd25;
    end else if (coin_ev[1]) begin
      coin_val = 10'd10;
    end else if (coin_ev[0]) begin
      coin_val = 10'd5;
    end else begin
      coin_val = 10'd0;
    end
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      credit_q    <= '0;
      change_q    <= '0;
      vendok_q    <= 1'b0;
      vendfail_q  <= 1'b0;
      outreject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      credit_q    <= credit_d;
      change_q    <= change_d;
      vendok_q    <= vendok_d;
      vendfail_q  <= vendfail_d;
      outreject_q <= outreject_d;
    end
  end

  // Next-state logic: requests take priority over coins; cancel beats vend.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    credit_d    = credit_q;
    change_d    = '0;
    vendok_d    = 1'b0;
    vendfail_d  = 1'b0;
    outreject_d = 1'b0;
    req_taken   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cancel) begin
          if (credit_q != '0) begin
            req_taken = 1'b1;
            change_d  = credit_q;
            credit_d  = '0;
            state_d   = StPayout;
          end
        end else if (vend) begin
          req_taken = 1'b1;
          if (price != '0 && credit_q >= price) begin
            vendok_d = 1'b1;
            credit_d = '0;
            if (credit_q != price) begin
              change_d = credit_q - price;
              state_d  = StPayout;
            end
          end else begin
            vendfail_d = 1'b1;
          end
        end
        if (coin_ev != '0) begin
          if (req_taken || multi_ev || coin_sum > MaxCredit) begin
            outreject_d = 1'b1;
          end else begin
            credit_d = coin_sum[9:0];
          end
        end
      end
      StPayout: begin
        outreject_d = (coin_ev != '0);
        hold_d      = HoldLoad;
        state_d     = StHold;
      end
      StHold: begin
        outreject_d = (coin_ev != '0);
        if (hold_q == '0) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign credit    = credit_q;
  assign change    = change_q;
  assign vendok    = vendok_q;
  assign vendfail  = vendfail_q;
  assign outreject = outreject_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: pulse outputs are checked against a scoreboard of expected
// events; credit, busy length and reset state are checked inline.
module tb_coin_acceptor;

  localparam int Hold      = 64;
  localparam int MaxCredit = 1000;
`ifdef COIN_DEBOUNCE_EN
  localparam int CoinHigh = 6;
`else
  localparam int CoinHigh = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inquarter = 1'b0, indime = 1'b0, innickel = 1'b0;
  logic [9:0] price = '0;
  logic       vend = 1'b0, cancel = 1'b0;
  logic [9:0] credit, change;
  logic       vendok, vendfail, outreject, busy;

  typedef struct {
    string      tag;
    logic [22:0] val;  // {vendok, vendfail, outreject, change, credit}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_credit = 0;

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .inquarter (inquarter),
    .indime    (indime),
    .innickel  (innickel),
    .price     (price),
    .vend      (vend),
    .cancel    (cancel),
    .credit    (credit),
    .vendok    (vendok),
    .vendfail  (vendfail),
    .outreject (outreject),
    .change    (change),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input bit vok, input bit vf, input bit rej,
                      input int chg, input int cr);
    exp_t e;
    e.tag = tag;
    e.val = {vok, vf, rej, 10'(chg), 10'(cr)};
    sb.push_back(e);
  endtask

  // Any pulse or nonzero change must match the oldest expected event.
  always @(negedge clk) begin
    if (rst === 1'b1 && (vendok || vendfail || outreject || change != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {9'd0, vendok, vendfail, outreject, change, credit}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, {9'd0, vendok, vendfail, outreject, change, credit}, {9'd0, e.val});
      end
    end
  end

  // mask bits: [2] quarter, [1] dime, [0] nickel.
  task automatic coin(input logic [2:0] mask, input bit blocked, input string tag);
    int val;
    int n;
    n   = int'(mask[0]) + int'(mask[1]) + int'(mask[2]);
    val = mask[2] ? 25 : (mask[1] ? 10 : 5);
    if (n > 1 || blocked || exp_credit + val > MaxCredit) begin
      push({tag, "_reject"}, 0, 0, 1, 0, exp_credit);
    end else begin
      exp_credit += val;
    end
    {inquarter, indime, innickel} = mask;
    tick(CoinHigh);
    {inquarter, indime, innickel} = 3'b000;
    tick(8);
    chk({tag, "_credit"}, 32'(credit), 32'(exp_credit));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick(1);
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic request(input bit v, input bit c, input int pr, input bit measure,
                         input string tag);
    int pay;
    int n;
    pay = 0;
    if (c) begin
      if (exp_credit > 0) begin
        pay = exp_credit;
        push({tag, "_cancel"}, 0, 0, 0, pay, 0);
        exp_credit = 0;
      end
    end else if (v) begin
      if (pr != 0 && exp_credit >= pr) begin
        pay = exp_credit - pr;
        push({tag, "_vendok"}, 1, 0, 0, pay, 0);
        exp_credit = 0;
      end else begin
        push({tag, "_vendfail"}, 0, 1, 0, 0, exp_credit);
      end
    end
    vend   = v;
    cancel = c;
    price  = 10'(pr);
    tick(1);
    vend   = 1'b0;
    cancel = 1'b0;
    chk({tag, "_credit"}, 32'(credit), 32'(exp_credit));
    chk({tag, "_busy"}, 32'(busy), 32'(pay > 0));
    if (pay > 0 && measure) begin
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
        n++;
        tick(1);
      end
      chk({tag, "_busy_len"}, 32'(n), 32'(Hold + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    chk("reset_outputs", {8'd0, vendok, vendfail, outreject, busy, change, credit}, 32'd0);
    rst = 1'b1;
    tick(2);

    coin(3'b100, 0, "quarter");
    coin(3'b010, 0, "dime");
    coin(3'b001, 0, "nickel");
    request(1, 0, 25, 1, "vend25_at40");

    coin(3'b010, 0, "dime_a");
    coin(3'b010, 0, "dime_b");
    request(1, 0, 25, 1, "vend25_at20");
    request(1, 0, 0, 1, "vend_price0");

    request(0, 1, 0, 0, "cancel20");
    tick(3);
    coin(3'b001, 1, "coin_in_hold");
    wait_idle("after_hold");

    coin(3'b100, 0, "q30");
    coin(3'b001, 0, "n30");
    request(1, 1, 25, 1, "vend_cancel30");

    repeat (39) coin(3'b100, 0, "fill_q");
    coin(3'b010, 0, "fill_d");
    coin(3'b001, 0, "fill_n");
    chk("credit_990", 32'(credit), 32'd990);
    coin(3'b010, 0, "dime_to_cap");
    chk("credit_cap", 32'(credit), 32'(MaxCredit));
    coin(3'b001, 0, "nickel_over_cap");
    request(1, 0, 1000, 1, "vend_exact");
    coin(3'b110, 0, "quarter_dime_together");
    request(0, 1, 0, 1, "cancel_at0");

`ifdef COIN_DEBOUNCE_EN
    innickel = 1'b1;
    tick(2);
    innickel = 1'b0;
    tick(10);
    chk("glitch_no_event", 32'(credit), 32'(exp_credit));
    coin(3'b001, 0, "nickel_6cyc");
`endif

    coin(3'b100, 0, "pre_reset_q");
    request(0, 1, 0, 0, "cancel_then_reset");
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_mid_hold", {8'd0, vendok, vendfail, outreject, busy, change, credit}, 32'd0);
    inquarter = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(10);
    inquarter = 1'b0;
    tick(10);
    exp_credit = 25;
    chk("held_across_reset", 32'(credit), 32'(exp_credit));

    tick(20);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Coin intake and credit controller for the vending machine; the payment-side counterpart of the coin dispenser. It synchronizes and edge-detects the quarter/dime/nickel sensor lines, accumulates credit up to a cap, and serves vend/cancel requests from the product controller. Any balance returned to the customer is issued as a one-cycle `change` value, the format the coin dispenser latches. A hold-off period follows each payout so the dispenser can finish before the next one is issued.

## Interface
- `MAX_CREDIT`, 1000: credit cap in cents; legal range 25..1023.
- `PAYOUT_HOLD`, 64: cycles `busy` stays high after a payout; legal range 1..255.
- `DEBOUNCE_CYCLES`, 4: consecutive high samples required per coin; only used with `COIN_DEBOUNCE_EN`; legal range 1..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inquarter`, `indime`, `innickel`  in  1 each  raw coin sensor lines, asynchronous, high while a coin passes.
- `price`  in  10  item price in cents; sampled with `vend`.
- `vend`  in  1  purchase request, 1-cycle pulse.
- `cancel`  in  1  refund request, 1-cycle pulse.
- `credit`  out  10  current credit in cents.
- `vendok`  out  1  1-cycle pulse: purchase accepted.
- `vendfail`  out  1  1-cycle pulse: insufficient credit or `price`==0.
- `outreject`  out  1  1-cycle pulse: coin routed to the return chute.
- `change`  out  10  payout amount; nonzero for exactly one cycle, 0 otherwise.
- `busy`  out  1  high during PAYOUT and HOLD.

## Operation
- Each coin line passes through a 2-flop synchronizer followed by a registered previous-value flop. A coin event is a synchronized rising edge.
- Coin values: quarter = 25, dime = 10, nickel = 5.
- States:
  - IDLE: accepts coins, vend and cancel.
  - PAYOUT: one cycle.
  - HOLD: counts down `PAYOUT_HOLD` cycles, then returns to IDLE.
- Coin handling in IDLE:
  - A single coin event is accepted if `credit` + value <= `MAX_CREDIT`; otherwise it is rejected. A coin exactly reaching the cap is accepted.
  - Two or more coin events in the same cycle: all are rejected with one `outreject` pulse, and credit is unchanged.
  - A coin event in PAYOUT or HOLD is rejected.
- Vend in IDLE:
  - Success when `price` != 0 and `credit` >= `price`. The block pulses `vendok` and computes remainder = `credit` − `price`.
  - If remainder > 0, go to PAYOUT with `change` = remainder. If remainder == 0, `credit` becomes 0 and the block stays in IDLE.
  - On failure, pulse `vendfail`; credit and state are unchanged.
- Cancel in IDLE: if `credit` > 0, go to PAYOUT with `change` = `credit`. If `credit` is 0, it is a no-op with no pulse.
- Priority:
  - `cancel` and `vend` in the same cycle: cancel wins and vend is dropped silently.
  - A coin event in the same cycle as a processed vend or cancel is rejected.
- `vend` and `cancel` in PAYOUT or HOLD are ignored, with no pulses.
- `credit` is 0 from entry to PAYOUT onward.

## Timing
- Reset values: `credit`, `change` = 0; `vendok`, `vendfail`, `outreject`, `busy` = 0. Synchronizer and edge flops clear to 0, and state is IDLE.
  - A line held high across reset release is therefore counted once.
  - Reset asserted mid-PAYOUT or mid-HOLD discards the pending payout.
- Coin latency without debounce: with the line high before edge k, the credit update or `outreject` is visible after edge k+2.
- Vend/cancel sampled at edge t:
  - `vendok`/`vendfail` and `credit` update after edge t.
  - In the same update, `change` goes nonzero and `busy` goes to 1.
  - `change` returns to 0 after edge t+1.
  - `busy` falls after edge t+1+`PAYOUT_HOLD`.
  - A new request is accepted at the first edge where `busy` was 0.
- All pulse outputs last exactly one cycle. `change` is always preceded by a 0 cycle, so the dispenser's 0→nonzero detection holds.
- Arithmetic is 10-bit unsigned. The cap compare uses an 11-bit sum, so no wrap is possible.

## Configuration
- `COIN_DEBOUNCE_EN` defined:
  - Each synchronized line must be high for `DEBOUNCE_CYCLES` consecutive cycles to produce one event. Coin latency grows by `DEBOUNCE_CYCLES`−1 cycles.
  - The line must then be low for `DEBOUNCE_CYCLES` consecutive cycles before that line re-arms.
  - A shorter glitch produces nothing.
- Undefined: every synchronized rising edge is an event, and `DEBOUNCE_CYCLES` is unused.

## Test plan
- Reset, then quarter, dime, nickel one at a time with gaps -> `credit` 25, 35, 40; no `outreject`.
- Credit 40, `vend` with `price`=25 -> `vendok` pulse; `change`=15 for one cycle; `busy` high 1+`PAYOUT_HOLD` cycles; `credit`=0.
- Credit 20, `vend` with `price`=25 -> `vendfail` pulse; `credit` stays 20; `change` stays 0.
- Credit 990 with `MAX_CREDIT`=1000: dime -> `credit`=1000; then nickel -> `outreject`, `credit` stays 1000. Separately, quarter and dime rising together -> one `outreject`, no credit change.
- Coin inserted during HOLD -> `outreject`. `vend` together with `cancel` at credit 30 -> `change`=30, no `vendok`.
- With `COIN_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=4: a 2-cycle nickel glitch -> no event; a 6-cycle nickel -> `credit` +5 exactly once.
